// File: rtl/md_ctrl.sv
// HI/LO multiply-divide controller: iterative-latency MULT/DIV unit with MTHI/MTLO writes.
// Optional multiply-accumulate (op 6/7) enabled by defining MD_CTRL_MADD_EN.
module md_ctrl #(
   parameter int unsigned MUL_CYC = 5,
   parameter int unsigned DIV_CYC = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        md_use_D,
   input  logic        exc_int,
   output logic        start,
   output logic        busy,
   output logic        done,
   output logic        stall_md,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [3:0] MUL_LD = 4'(MUL_CYC - 1);
   localparam logic [3:0] DIV_LD = 4'(DIV_CYC - 1);

   logic [0:0]  state;
   logic [3:0]  cnt;
   logic [63:0] res_q;
   logic        skip_q;
`ifdef MD_CTRL_MADD_EN
   logic        acc_q;
`endif

   logic        is_md;
   logic        is_div;
   logic [63:0] res_d;
   logic [63:0] ps, pu;
   logic [31:0] dvs, uq, ur, a_mag, b_mag, sq_m, sr_m, sq, sr;

   always_comb begin
      is_div = (op == 3'd2) || (op == 3'd3);
`ifdef MD_CTRL_MADD_EN
      is_md  = (op != 3'd4) && (op != 3'd5);
`else
      is_md  = (op <= 3'd3);
`endif
   end

   assign busy     = (state == RUN);
   assign start    = op_valid & is_md & ~busy & ~exc_int;
   assign done     = busy & (cnt == 4'd0);
   assign stall_md = md_use_D & (start | busy);

   // Low 64 bits of the product of sign-extended operands equal the signed product.
   always_comb begin
      ps    = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
      pu    = {32'd0, rs_val} * {32'd0, rt_val};
      dvs   = (rt_val == '0) ? 32'd1 : rt_val;
      uq    = rs_val / dvs;
      ur    = rs_val % dvs;
      // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow corner.
      a_mag = rs_val[31] ? -rs_val : rs_val;
      b_mag = dvs[31] ? -dvs : dvs;
      sq_m  = a_mag / b_mag;
      sr_m  = a_mag % b_mag;
      sq    = (rs_val[31] ^ dvs[31]) ? -sq_m : sq_m;
      sr    = rs_val[31] ? -sr_m : sr_m;
      case (op)
         3'd0, 3'd6: res_d = ps;
         3'd1, 3'd7: res_d = pu;
         3'd2:       res_d = {sr, sq};
         3'd3:       res_d = {ur, uq};
         default:    res_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         res_q  <= '0;
         skip_q <= 1'b0;
`ifdef MD_CTRL_MADD_EN
         acc_q  <= 1'b0;
`endif
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  cnt    <= is_div ? DIV_LD : MUL_LD;
                  res_q  <= res_d;
                  skip_q <= is_div && (rt_val == '0);
`ifdef MD_CTRL_MADD_EN
                  acc_q  <= (op == 3'd6) || (op == 3'd7);
`endif
               end else if (op_valid && !exc_int && op == 3'd4) begin
                  hi <= rs_val;
               end else if (op_valid && !exc_int && op == 3'd5) begin
                  lo <= rs_val;
               end
            end
            RUN: begin
               if (cnt == 4'd0) begin
                  state <= IDLE;
`ifdef MD_CTRL_MADD_EN
                  if (acc_q)
                     {hi, lo} <= {hi, lo} + res_q;
                  else if (!skip_q)
                     {hi, lo} <= res_q;
`else
                  if (!skip_q)
                     {hi, lo} <= res_q;
`endif
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl: latency, results, MTHI/MTLO, stall, flush, reset.
module tb_md_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        md_use_D, exc_int;
   logic        start, busy, done, stall_md;
   logic [31:0] hi, lo;

   int pass_cnt = 0;
   int total    = 0;

   md_ctrl #(.MUL_CYC(5), .DIV_CYC(10)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .md_use_D(md_use_D), .exc_int(exc_int),
      .start(start), .busy(busy), .done(done), .stall_md(stall_md),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Issues one op at cycle T; returns busy-cycle count, done cycle offset, and start at T.
   // Leaves the bench at T+N+1 (#1 after the edge) once busy drops; bounded at 20 cycles.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bcnt, output int done_at, output logic st);
      @(posedge clk); #1;
      op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
      #1 st = start;
      @(posedge clk); #1;
      op_valid = 1'b0; rs_val = $urandom; rt_val = $urandom;
      bcnt = 0; done_at = -1;
      for (int i = 1; i <= 20; i++) begin
         if (busy) bcnt++;
         if (done) done_at = i;
         if (!busy) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] v);
      @(posedge clk); #1;
      op_valid = 1'b1; op = o; rs_val = v;
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; op_valid = 1'b0; op = '0; rs_val = '0; rt_val = '0;
      md_use_D = 1'b0; exc_int = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (hi !== 32'd0) $display("FAIL reset_hi got=%h exp=0", hi); else pass_cnt++;
      total++; if (lo !== 32'd0) $display("FAIL reset_lo got=%h exp=0", lo); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
      total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
      total++; if (stall_md !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_md); else pass_cnt++;
      reset = 1'b0;
   endtask

   task automatic test_mult;
      int bc, da; logic st;
      do_op(3'd0, 32'hFFFFFFFE, 32'd3, bc, da, st);
      total++; if (st !== 1'b1) $display("FAIL mult_start got=%b exp=1", st); else pass_cnt++;
      total++; if (bc !== 5) $display("FAIL mult_busy got=%0d exp=5", bc); else pass_cnt++;
      total++; if (da !== 5) $display("FAIL mult_done got=%0d exp=5", da); else pass_cnt++;
      total++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi got=%h exp=ffffffff", hi); else pass_cnt++;
      total++; if (lo !== 32'hFFFFFFFA) $display("FAIL mult_lo got=%h exp=fffffffa", lo); else pass_cnt++;
      do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, da, st);
      total++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi got=%h exp=fffffffe", hi); else pass_cnt++;
      total++; if (lo !== 32'h00000001) $display("FAIL multu_lo got=%h exp=1", lo); else pass_cnt++;
   endtask

   task automatic test_div;
      int bc, da; logic st;
      do_op(3'd3, 32'd100, 32'd7, bc, da, st);
      total++; if (bc !== 10) $display("FAIL divu_busy got=%0d exp=10", bc); else pass_cnt++;
      total++; if (da !== 10) $display("FAIL divu_done got=%0d exp=10", da); else pass_cnt++;
      total++; if (lo !== 32'd14) $display("FAIL divu_lo got=%h exp=e", lo); else pass_cnt++;
      total++; if (hi !== 32'd2) $display("FAIL divu_hi got=%h exp=2", hi); else pass_cnt++;
      do_op(3'd2, 32'hFFFFFFF9, 32'd2, bc, da, st);
      total++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo got=%h exp=fffffffd", lo); else pass_cnt++;
      total++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi got=%h exp=ffffffff", hi); else pass_cnt++;
      do_op(3'd2, 32'd7, 32'hFFFFFFFE, bc, da, st);
      total++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_neg_lo got=%h exp=fffffffd", lo); else pass_cnt++;
      total++; if (hi !== 32'd1) $display("FAIL div_neg_hi got=%h exp=1", hi); else pass_cnt++;
   endtask

   task automatic test_div_zero;
      int bc, da; logic st;
      mt(3'd4, 32'hAA);
      mt(3'd5, 32'hBB);
      do_op(3'd2, 32'd5, 32'd0, bc, da, st);
      total++; if (bc !== 10) $display("FAIL div0_busy got=%0d exp=10", bc); else pass_cnt++;
      total++; if (da !== 10) $display("FAIL div0_done got=%0d exp=10", da); else pass_cnt++;
      total++; if (hi !== 32'hAA) $display("FAIL div0_hi got=%h exp=aa", hi); else pass_cnt++;
      total++; if (lo !== 32'hBB) $display("FAIL div0_lo got=%h exp=bb", lo); else pass_cnt++;
   endtask

   task automatic test_exc_mthi;
      @(posedge clk); #1;
      op_valid = 1'b1; op = 3'd0; rs_val = 32'd9; rt_val = 32'd9; exc_int = 1'b1;
      #1;
      total++; if (start !== 1'b0) $display("FAIL exc_start got=%b exp=0", start); else pass_cnt++;
      @(posedge clk); #1;
      op_valid = 1'b0; exc_int = 1'b0;
      total++; if (busy !== 1'b0) $display("FAIL exc_busy got=%b exp=0", busy); else pass_cnt++;
      // MTHI under flush must not write
      @(posedge clk); #1;
      op_valid = 1'b1; op = 3'd4; rs_val = 32'hDEADBEEF; exc_int = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0; exc_int = 1'b0;
      total++; if (hi !== 32'hAA) $display("FAIL exc_mthi got=%h exp=aa", hi); else pass_cnt++;
      @(posedge clk); #1;
      op_valid = 1'b1; op = 3'd4; rs_val = 32'h12345678;
      #1;
      total++; if (start !== 1'b0) $display("FAIL mthi_start got=%b exp=0", start); else pass_cnt++;
      @(posedge clk); #1;
      op_valid = 1'b0;
      total++; if (hi !== 32'h12345678) $display("FAIL mthi_hi got=%h exp=12345678", hi); else pass_cnt++;
      total++; if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL mthi_busy got=%b%b exp=00", busy, done); else pass_cnt++;
   endtask

   task automatic test_stall_exc;
      int bad = 0;
      md_use_D = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b1; op = 3'd0; rs_val = 32'd7; rt_val = 32'd6;
      #1;
      total++; if (stall_md !== 1'b1) $display("FAIL stall_start got=%b exp=1", stall_md); else pass_cnt++;
      @(posedge clk); #1;
      op_valid = 1'b0; rs_val = 32'd1000; rt_val = 32'd1000;
      for (int i = 1; i <= 5; i++) begin
         if (stall_md !== 1'b1 || busy !== 1'b1) bad++;
         exc_int = (i == 2);
         @(posedge clk); #1;
      end
      exc_int = 1'b0;
      total++; if (bad !== 0) $display("FAIL stall_run got=%0d bad cycles exp=0", bad); else pass_cnt++;
      total++; if (stall_md !== 1'b0) $display("FAIL stall_after got=%b exp=0", stall_md); else pass_cnt++;
      total++; if (lo !== 32'd42 || hi !== 32'd0)
         $display("FAIL stall_commit got=%h_%h exp=0_2a", hi, lo); else pass_cnt++;
      md_use_D = 1'b0;
   endtask

   task automatic test_busy_ignore;
      @(posedge clk); #1;
      op_valid = 1'b1; op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
      @(posedge clk); #1;
      op = 3'd4; rs_val = 32'hDEAD;
      #1;
      total++; if (start !== 1'b0) $display("FAIL ignore_start got=%b exp=0", start); else pass_cnt++;
      @(posedge clk); #1;
      op = 3'd2; rt_val = 32'd1;
      repeat (4) @(posedge clk);
      #1;
      op_valid = 1'b0;
      total++; if (hi !== 32'd0 || lo !== 32'd6 || busy !== 1'b0)
         $display("FAIL ignore_commit got=%h_%h busy=%b exp=0_6 busy=0", hi, lo, busy); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      op_valid = 1'b1; op = 3'd3; rs_val = 32'd50; rt_val = 32'd5;
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else pass_cnt++;
      total++; if (hi !== 32'd0 || lo !== 32'd0)
         $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi, lo); else pass_cnt++;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      total++; if (lo !== 32'd0) $display("FAIL rstmid_discard got=%h exp=0", lo); else pass_cnt++;
   endtask

   task automatic test_madd;
      int bc, da; logic st;
      mt(3'd5, 32'd5);
`ifdef MD_CTRL_MADD_EN
      do_op(3'd7, 32'd3, 32'd4, bc, da, st);
      total++; if (bc !== 5) $display("FAIL maddu_busy got=%0d exp=5", bc); else pass_cnt++;
      total++; if (hi !== 32'd0 || lo !== 32'd17)
         $display("FAIL maddu_res got=%h_%h exp=0_11", hi, lo); else pass_cnt++;
      do_op(3'd6, 32'hFFFFFFFF, 32'd20, bc, da, st);
      total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
         $display("FAIL madd_res got=%h_%h exp=ffffffff_fffffffd", hi, lo); else pass_cnt++;
`else
      do_op(3'd7, 32'd3, 32'd4, bc, da, st);
      total++; if (st !== 1'b0) $display("FAIL madd_off_start got=%b exp=0", st); else pass_cnt++;
      total++; if (bc !== 0) $display("FAIL madd_off_busy got=%0d exp=0", bc); else pass_cnt++;
      total++; if (hi !== 32'd0 || lo !== 32'd5)
         $display("FAIL madd_off_res got=%h_%h exp=0_5", hi, lo); else pass_cnt++;
`endif
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_div_zero;
      test_exc_mthi;
      test_stall_exc;
      test_busy_ignore;
      test_reset_mid;
      test_madd;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
